// File: rtl/xxhash32_stream.sv
// xxhash32_stream: streaming XXH32 engine with a seeded start, a byte
// stream input of IN_WORDS words per beat and a valid/ready hash output.
`timescale 1ns/1ps
module xxhash32_stream #(
    parameter int IN_WORDS = 4,
    parameter int BYTES_W  = $clog2(4*IN_WORDS+1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [31:0]             seed,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*IN_WORDS-1:0]  in_data,
    input  logic                    in_last,
    input  logic [BYTES_W-1:0]      in_bytes,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_hash
);

    localparam logic [31:0] P1 = 32'h9E3779B1;
    localparam logic [31:0] P2 = 32'h85EBCA77;
    localparam logic [31:0] P3 = 32'hC2B2AE3D;
    localparam logic [31:0] P4 = 32'h27D4EB2F;
    localparam logic [31:0] P5 = 32'h165667B1;
    localparam logic [BYTES_W-1:0] FULL = BYTES_W'(4*IN_WORDS);

    typedef enum logic [2:0] {
        IDLE, ACCEPT, MERGE, TAIL, AVAL1, AVAL2, AVAL3, DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]       seed_q, len, h, hash_q;
    logic [3:0][31:0]  v, sbuf;
    logic [1:0]        ptr, tw, tb;
    logic [3:0]        pos;
    logic              big;

    logic              accept, wrap, stripe_done, tail_end;
    logic [BYTES_W-1:0] bytes_c;
    logic [3:0][31:0]  stripe, v_rnd;
    logic [31:0]       h_merge, h_tail, tail_word;
    logic [7:0]        tail_byte;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACCEPT);
    assign out_valid = (state == DONE);
    assign out_hash  = hash_q;

    assign accept = in_valid && (state == ACCEPT);
    assign wrap   = ({1'b0, ptr} + 3'(IN_WORDS)) >= 3'd4;

    // Stripe view with this beat merged in, so lanes update on the accepting edge.
    always_comb begin
        bytes_c = (in_bytes > FULL) ? FULL : in_bytes;
        stripe  = sbuf;
        for (int i = 0; i < IN_WORDS; i++)
            stripe[ptr + 2'(i)] = in_data[32*i +: 32];
        for (int j = 0; j < 4; j++)
            v_rnd[j] = rotl(v[j] + stripe[j] * P2, 13) * P1;
    end

    // Only a fully populated stripe is consumed; partial ones stay as tail.
    assign stripe_done = accept && wrap && (bytes_c == FULL);

    assign h_merge = (big ? rotl(v[0], 1) + rotl(v[1], 7) +
                            rotl(v[2], 12) + rotl(v[3], 18)
                          : seed_q + P5) + len;

    assign tail_word = sbuf[pos[3:2]];
    assign tail_byte = tail_word[{pos[1:0], 3'b000} +: 8];
    assign h_tail    = (tw != 2'd0)
                     ? rotl(h + tail_word * P3, 17) * P4
                     : rotl(h + {24'b0, tail_byte} * P5, 11) * P1;
    assign tail_end  = ({1'b0, tw} + {1'b0, tb}) == 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = ACCEPT;
            ACCEPT: if (in_valid && in_last) state_nxt = MERGE;
            MERGE:  state_nxt = (len[3:0] == 4'd0) ? AVAL1 : TAIL;
            TAIL:   if (tail_end) state_nxt = AVAL1;
            AVAL1:  state_nxt = AVAL2;
            AVAL2:  state_nxt = AVAL3;
            AVAL3:  state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= '0;
            len    <= '0;
            h      <= '0;
            hash_q <= '0;
            v      <= '0;
            sbuf   <= '0;
            ptr    <= '0;
            tw     <= '0;
            tb     <= '0;
            pos    <= '0;
            big    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        seed_q <= seed;
                        v[0]   <= seed + P1 + P2;
                        v[1]   <= seed + P2;
                        v[2]   <= seed;
                        v[3]   <= seed - P1;
                        len    <= '0;
                        ptr    <= '0;
                        big    <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        sbuf <= stripe;
                        ptr  <= ptr + 2'(IN_WORDS);
                        len  <= len + 32'(bytes_c);
                        if (stripe_done) begin
                            v   <= v_rnd;
                            big <= 1'b1;
                        end
                    end
                end
                MERGE: begin
                    h   <= h_merge;
                    tw  <= len[3:2];
                    tb  <= len[1:0];
                    pos <= '0;
                end
                TAIL: begin
                    h <= h_tail;
                    if (tw != 2'd0) begin
                        tw  <= tw - 2'd1;
                        pos <= pos + 4'd4;
                    end else begin
                        tb  <= tb - 2'd1;
                        pos <= pos + 4'd1;
                    end
                end
                AVAL1: h <= (h ^ (h >> 15)) * P2;
                AVAL2: h <= (h ^ (h >> 13)) * P3;
                AVAL3: begin
                    h      <= h ^ (h >> 16);
                    hash_q <= h ^ (h >> 16);
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule
